// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- fans a start/valid/stop control stream out to CH channels,
// each delayed by 1 + d_c cycles. d_c is captured from `delay` when a frame's
// start is accepted. The whole block stalls unless every downstream channel
// is ready.
//
// Ports:
//   clk, rst        clock (rising edge) and async active-high reset
//   delay[CH*DW]    per-channel extra delay, channel c at [c*DW +: DW]
//   s_start/s_valid/s_stop, s_ready   upstream token handshake
//   m_start/m_valid/m_stop [CH]       registered per-channel delayed tokens
//   m_ready[CH]     downstream ready; block advances only when all are high
//   busy            high while a frame is in progress (state != IDLE)
//   err             sticky protocol-error flag
module ctrl_pipe #(
    parameter int CH       = 4,
    parameter int MAXDELAY = 16,
    parameter int DW       = $clog2(MAXDELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*DW-1:0] delay,
    input  logic             s_start,
    input  logic             s_valid,
    input  logic             s_stop,
    output logic             s_ready,
    output logic [CH-1:0]    m_start,
    output logic [CH-1:0]    m_valid,
    output logic [CH-1:0]    m_stop,
    input  logic [CH-1:0]    m_ready,
    output logic             busy,
    output logic             err
);

    localparam logic [DW-1:0] DMAX = DW'(MAXDELAY);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_d;
    logic          adv;
    logic          load;       // start accepted: latch per-channel delays
    logic          ins;        // insert tok into the shift lines
    logic [2:0]    tok;        // {start, valid, stop}
    logic          err_set;
    logic [CH-1:0] stop_pend;  // a stop is still travelling in stages >= 1

    assign adv = &m_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic. Transitions only happen on advancing cycles.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (adv && s_start) state_d = s_stop ? DRAIN : RUN;
            RUN:   if (adv && s_stop)  state_d = DRAIN;
            // The last stop sits at stage 0 (on m_stop) once no stop remains
            // deeper in any line; leave DRAIN as it is emitted.
            DRAIN: if (adv && !(|stop_pend)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath control logic
    always_comb begin
        s_ready = adv && (state != DRAIN);
        busy    = (state != IDLE);
        load    = 1'b0;
        ins     = 1'b0;
        tok     = 3'b000;
        err_set = 1'b0;
        case (state)
            IDLE: if (s_ready) begin
                if (s_start) begin
                    load = 1'b1;
                    ins  = 1'b1;
                    tok  = {1'b1, s_valid, s_stop};
                end else if (s_valid || s_stop) begin
                    err_set = 1'b1;
                end
            end
            RUN: if (s_ready) begin
                // A repeated start is dropped, but valid/stop riding with it
                // still go through.
                if (s_start) err_set = 1'b1;
                if (s_valid || s_stop) begin
                    ins = 1'b1;
                    tok = {1'b0, s_valid, s_stop};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end

    // Per-channel shift lines. A token is inserted at stage d_c and shifts
    // toward stage 0, which is the output register. The delay is constant
    // within a frame, and a new frame cannot start before the old one has
    // drained, so tokens never collide and insertion can simply OR in.
    for (genvar c = 0; c < CH; c++) begin : gen_ch
        logic [DW-1:0]             d_q, d_cl, d_eff;
        logic [MAXDELAY:0][2:0]    line, nxt;
        logic                      sp;

        assign d_cl  = (delay[c*DW +: DW] > DMAX) ? DMAX : delay[c*DW +: DW];
        // The start token itself must use the delay being latched with it.
        assign d_eff = load ? d_cl : d_q;

        always_comb begin
            nxt = {3'b000, line[MAXDELAY:1]};
            if (ins) nxt[d_eff] = nxt[d_eff] | tok;
        end

        always_comb begin
            sp = 1'b0;
            for (int k = 1; k <= MAXDELAY; k++) sp = sp | line[k][0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                line <= '0;
                d_q  <= '0;
            end else if (adv) begin
                line <= nxt;
                if (load) d_q <= d_cl;
            end
        end

        assign m_start[c]   = line[0][2];
        assign m_valid[c]   = line[0][1];
        assign m_stop[c]    = line[0][0];
        assign stop_pend[c] = sp;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

    localparam int CH   = 4;
    localparam int MAXD = 16;
    localparam int DW   = 5;
    localparam int SZ   = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*DW-1:0] delay;
    logic             s_start, s_valid, s_stop;
    logic             s_ready;
    logic [CH-1:0]    m_start, m_valid, m_stop, m_ready;
    logic             busy, err;

    ctrl_pipe #(.CH(CH), .MAXDELAY(MAXD), .DW(DW)) dut (
        .clk(clk), .rst(rst), .delay(delay),
        .s_start(s_start), .s_valid(s_valid), .s_stop(s_stop), .s_ready(s_ready),
        .m_start(m_start), .m_valid(m_valid), .m_stop(m_stop), .m_ready(m_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: tokens are scheduled by advance count.
    // A token accepted while n advances have happened shows up on the
    // outputs once n+1+d advances have happened, and is held while stalled.
    int         n;
    int         mode;        // 0 idle, 1 in frame, 2 draining
    int         md[CH];
    int         last_stop;
    bit         merr;
    logic [2:0] sched [CH][SZ];
    int         n_asrt = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; mode = 0; merr = 0; last_stop = 0;
        for (int c = 0; c < CH; c++) begin
            md[c] = 0;
            for (int i = 0; i < SZ; i++) sched[c][i] = 3'b000;
        end
    endtask

    task automatic check_outs(input string tag);
        logic [CH-1:0] es, ev, ep;
        for (int c = 0; c < CH; c++) begin
            {es[c], ev[c], ep[c]} = sched[c][n % SZ];
        end
        chk({tag, ".m_start"}, m_start, es);
        chk({tag, ".m_valid"}, m_valid, ev);
        chk({tag, ".m_stop"},  m_stop,  ep);
        chk({tag, ".busy"},    busy,    mode != 0);
        chk({tag, ".err"},     err,     merr);
    endtask

    // One clock cycle: drive inputs at negedge, check s_ready, step the model,
    // check registered outputs just after the rising edge.
    task automatic step(input logic st, vl, sp, input logic [CH-1:0] mr,
                        input logic [CH*DW-1:0] dl);
        logic [2:0] tok;
        bit         ins, adv;
        int         f;
        s_start = st; s_valid = vl; s_stop = sp; m_ready = mr; delay = dl;
        #1;
        adv = &mr;
        chk("s_ready", s_ready, adv && mode != 2);
        ins = 0; tok = 3'b000;
        if (adv) begin
            case (mode)
                0: if (st) begin
                       for (int c = 0; c < CH; c++) begin
                           f = int'(dl[c*DW +: DW]);
                           md[c] = (f > MAXD) ? MAXD : f;
                       end
                       ins = 1; tok = {1'b1, vl, sp};
                       mode = sp ? 2 : 1;
                   end else if (vl || sp) merr = 1;
                1: begin
                       if (st) merr = 1;
                       if (vl || sp) begin
                           ins = 1; tok = {1'b0, vl, sp};
                           if (sp) mode = 2;
                       end
                   end
                default: if (n == last_stop) mode = 0;
            endcase
            if (ins) begin
                for (int c = 0; c < CH; c++) begin
                    sched[c][(n + 1 + md[c]) % SZ] = tok;
                    if (tok[0] && (n + 1 + md[c]) > last_stop) last_stop = n + 1 + md[c];
                end
            end
            n++;
            for (int c = 0; c < CH; c++) sched[c][(n - 1) % SZ] = 3'b000;
        end
        @(posedge clk);
        #1;
        check_outs("cyc");
        @(negedge clk);
    endtask

    initial begin
        logic [CH*DW-1:0] d0, d5, d1, d8, d31, rdl;
        logic [CH-1:0]    rmr;
        int               lat;

        d0  = {5'd0, 5'd1, 5'd2, 5'd3};   // ch0=3 .. ch3=0
        d5  = {5'd5, 5'd5, 5'd5, 5'd5};
        d1  = {5'd1, 5'd1, 5'd1, 5'd1};
        d8  = {5'd8, 5'd8, 5'd8, 5'd8};
        d31 = {5'd0, 5'd0, 5'd0, 5'd31};

        rst = 1'b1; s_start = 0; s_valid = 0; s_stop = 0; m_ready = '1; delay = d0;
        model_reset();
        #3;
        check_outs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic frame, all channels ready
        step(1, 0, 0, '1, d0);
        repeat (3) step(0, 1, 0, '1, d0);
        step(0, 1, 1, '1, d0);
        repeat (8) step(0, 0, 0, '1, d0);

        // Same frame with channel 2 stalling for three cycles
        step(1, 0, 0, '1, d0);
        step(0, 1, 0, '1, d0);
        repeat (3) step(0, 1, 0, 4'b1011, d0);
        step(0, 1, 0, '1, d0);
        step(0, 1, 0, '1, d0);
        step(0, 1, 1, '1, d0);
        repeat (8) step(0, 0, 0, '1, d0);

        // Clamped delay: 31 behaves as 16 -> latency 17
        step(1, 0, 0, '1, d31);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (m_start[0]) begin lat = i; break; end
            step(0, 0, 0, '1, d31);
        end
        chk("clamp_latency", lat, 17);
        step(0, 0, 1, '1, d31);
        repeat (20) step(0, 0, 0, '1, d31);

        // Delay changed mid-frame has no effect
        step(1, 1, 0, '1, d5);
        step(0, 1, 0, '1, d5);
        step(0, 1, 0, '1, d1);
        step(0, 1, 1, '1, d1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (m_stop[1]) begin lat = i; break; end
            step(0, 0, 0, '1, d1);
        end
        chk("latched_delay_stop", lat, 6);
        repeat (4) step(0, 0, 0, '1, d1);

        // Protocol errors: valid in idle, start inside a frame
        step(0, 1, 0, '1, d0);
        chk("err_set", err, 1);
        step(1, 0, 0, '1, d0);
        step(1, 1, 0, '1, d0);
        step(0, 1, 0, '1, d0);
        step(0, 0, 1, '1, d0);
        repeat (8) step(0, 0, 0, '1, d0);
        chk("err_sticky", err, 1);

        // Reset in the middle of a frame
        step(1, 0, 0, '1, d8);
        step(0, 1, 0, '1, d8);
        step(0, 1, 0, '1, d8);
        rst = 1'b1;
        #1;
        model_reset();
        check_outs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (15) step(0, 0, 0, '1, d8);
        step(1, 1, 0, '1, d8);
        step(0, 1, 1, '1, d8);
        repeat (12) step(0, 0, 0, '1, d8);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) rdl[c*DW +: DW] = DW'($urandom_range(0, 31));
            rmr = ($urandom % 5 == 0) ? CH'($urandom) : '1;
            step(($urandom % 6) == 0, ($urandom % 2) == 0, ($urandom % 5) == 0, rmr, rdl);
        end
        repeat (25) step(0, 0, 0, '1, d0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
